// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready word port, a one-word
// holding buffer so consecutive words stream with no idle bit between them.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             active_q, active_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             word_done_q, word_done_d;

    logic at_last;
    logic consume_last;
    logic accept;
    logic load;

    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        active_d     = active_q;
        bit_cnt_d    = bit_cnt_q;

        at_last      = active_q && (bit_cnt_q == LAST_IDX);
        consume_last = at_last && shift_en;
        accept       = in_valid && in_ready;
        load         = hold_full_q && (!active_q || consume_last);
        word_done_d  = consume_last;

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        // A held word replaces the finishing one on the same edge, keeping the line gap-free.
        if (load) begin
            shift_d     = hold_q;
            active_d    = 1'b1;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
        end else if (active_q && shift_en && !at_last) begin
            if (LSB_FIRST)
                shift_d = {1'b0, shift_q[WIDTH-1:1]};
            else
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (consume_last) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            active_q    <= 1'b0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign in_ready   = !reset && !hold_full_q;
    assign serial_out = active_q ? (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1]) : IDLE_LEVEL;
    assign bit_valid  = active_q;
    assign first_bit  = active_q && (bit_cnt_q == '0);
    assign last_bit   = at_last;
    assign word_done  = word_done_q;
    assign busy       = active_q || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share stimulus and
// are compared each cycle against a word/bit-position reference model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] in_data = '0;

    logic rdy_m, so_m, bv_m, fb_m, lb_m, wd_m, bz_m;
    logic rdy_l, so_l, bv_l, fb_l, lb_l, wd_l, bz_l;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: current word plus its transmit position (-1 = idle), and the held words.
    int           pos = -1;
    logic [W-1:0] cur = '0;
    logic [W-1:0] pend[$];
    bit           done_m = 1'b0;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
        .in_data(in_data), .shift_en(shift_en), .serial_out(so_m), .bit_valid(bv_m),
        .first_bit(fb_m), .last_bit(lb_m), .word_done(wd_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .shift_en(shift_en), .serial_out(so_l), .bit_valid(bv_l),
        .first_bit(fb_l), .last_bit(lb_l), .word_done(wd_l), .busy(bz_l)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {rdy_m, so_m, bv_m, fb_m, lb_m, wd_m, bz_m,
                       rdy_l, so_l, bv_l, fb_l, lb_l, wd_l, bz_l};

    function automatic logic [6:0] exp_vec(input bit lsb, input bit idle);
        bit   act;
        logic s;
        act = (pos >= 0);
        if (act) s = cur[lsb ? pos : (W - 1 - pos)];
        else     s = idle;
        return {!reset && (pend.size() == 0), s, act, act && (pos == 0),
                act && (pos == W - 1), done_m, act || (pend.size() != 0)};
    endfunction

    function automatic logic [13:0] exp_all();
        return {exp_vec(1'b0, 1'b0), exp_vec(1'b1, 1'b1)};
    endfunction

    function automatic logic [W-1:0] bit_reverse(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_clear();
        pos    = -1;
        pend   = {};
        done_m = 1'b0;
    endtask

    task automatic model_step();
        bit can_take, fin, adv;
        if (reset) begin
            model_clear();
            return;
        end
        can_take = (pend.size() == 0);
        fin      = (pos == W - 1) && shift_en;
        adv      = (pos >= 0) && (pos < W - 1) && shift_en;
        done_m   = fin;
        if (pend.size() != 0 && (pos < 0 || fin)) begin
            cur = pend.pop_front();
            pos = 0;
        end else if (adv) begin
            pos++;
        end else if (fin) begin
            pos = -1;
        end
        if (in_valid && can_take) pend.push_back(in_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        shift_en = 1'b1;
        in_data  = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({rdy_m, rdy_l} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_release_ready got=%b exp=11", {rdy_m, rdy_l});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] acc_m = '0, acc_l = '0;
        int nbits = 0, ndone = 0;
        in_valid = 1'b1;
        in_data  = 8'hB4;
        shift_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            in_valid = 1'b0;
            if (bv_m) begin acc_m = {acc_m[W-2:0], so_m}; nbits++; end
            if (bv_l) acc_l = {acc_l[W-2:0], so_l};
            if (wd_m) ndone++;
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL single cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        total++;
        if (acc_m !== 8'hB4 || acc_l !== 8'h2D || nbits != 8 || ndone != 1) begin
            bad++;
            $display("[TB] FAIL single_stream got msb=%h lsb=%h bits=%0d done=%0d exp msb=b4 lsb=2d bits=8 done=1",
                     acc_m, acc_l, nbits, ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2] = '{8'hA5, 8'h3C};
        logic [2*W-1:0] acc_m = '0, acc_l = '0;
        int k = 0, nbits = 0, ndone = 0, gaps = 0;
        bit take;
        shift_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = (k < 2);
            in_data  = (k < 2) ? words[k] : '0;
            take     = in_valid && (pend.size() == 0);
            step();
            if (take) k++;
            if (bv_m) begin
                acc_m = {acc_m[2*W-2:0], so_m};
                acc_l = {acc_l[2*W-2:0], so_l};
                nbits++;
            end else if (nbits > 0 && nbits < 2 * W) begin
                gaps++;
            end
            if (wd_m) ndone++;
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc_m !== {8'hA5, 8'h3C} || acc_l !== {bit_reverse(8'hA5), bit_reverse(8'h3C)} ||
            nbits != 16 || gaps != 0 || ndone != 2) begin
            bad++;
            $display("[TB] FAIL b2b_stream got msb=%h lsb=%h bits=%0d gaps=%0d done=%0d exp msb=a53c bits=16 gaps=0 done=2",
                     acc_m, acc_l, nbits, gaps, ndone);
        end
    endtask

    task automatic test_slow_enable();
        int k = 0;
        bit take;
        for (int i = 0; i < 90; i++) begin
            in_valid = (k < 3);
            in_data  = W'($urandom);
            shift_en = (i % 3 == 2);
            take     = in_valid && (pend.size() == 0);
            step();
            if (take) k++;
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL slow_en cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        in_valid = 1'b0;
        shift_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] word, acc_m = '0, acc_l = '0;
        int guard = 0, nbits = 0;
        shift_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_data  = W'($urandom);
        while (!(pos == 3 && pend.size() != 0) && guard < 20) begin
            step();
            if (pend.size() != 0) in_valid = 1'b0;
            guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("[TB] FAIL midword_setup got pos=%0d held=%0d exp pos=3 held=1", pos, pend.size());
        end
        reset = 1'b1;
        in_valid = 1'b0;
        model_clear();
        #1;
        total++;
        if (obs !== exp_all()) begin
            bad++;
            $display("[TB] FAIL midword_async got=%b exp=%b", obs, exp_all());
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL midword_inreset cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        reset = 1'b0;
        word  = W'($urandom);
        in_valid = 1'b1;
        in_data  = word;
        for (int i = 0; i < 12; i++) begin
            step();
            in_valid = 1'b0;
            if (bv_m) begin
                acc_m = {acc_m[W-2:0], so_m};
                acc_l = {acc_l[W-2:0], so_l};
                nbits++;
            end
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL midword_after cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        total++;
        if (acc_m !== word || acc_l !== bit_reverse(word) || nbits != W) begin
            bad++;
            $display("[TB] FAIL midword_stream got msb=%h lsb=%h bits=%0d exp msb=%h lsb=%h bits=8",
                     acc_m, acc_l, nbits, word, bit_reverse(word));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = W'($urandom);
            shift_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            #1;
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL random_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
            step();
            total++;
            if (obs !== exp_all()) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_all());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_enable();
        test_reset_midword();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
